// File: rtl/wvb_rd_arb.sv
// wvb_rd_arb: round-robin arbiter that shares one waveform-buffer read controller and its DPRAM among P_N_CHAN channels.
// Optional completed-waveform counter is enabled by defining WVB_RD_ARB_EVT_CNT_EN.
module wvb_rd_arb #(
    parameter int P_N_CHAN    = 24,
    parameter int P_IDX_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [P_N_CHAN-1:0] wvb_pending,
    input  logic [P_N_CHAN-1:0] chan_en,
    input  logic                cfg_dpram_mode,
    output logic                rd_req,
    output logic [7:0]          rd_idx,
    output logic                rd_dpram_mode,
    input  logic                rd_ack,
    input  logic                rd_more,
    input  logic [15:0]         rd_dpram_len,
    output logic                dpram_rdy,
    output logic [15:0]         dpram_len,
    output logic [7:0]          dpram_idx,
    output logic                dpram_cont,
    input  logic                dpram_done,
    output logic [31:0]         n_evt
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_HOST} state_t;

    state_t                   state, state_nxt;
    logic [P_IDX_WIDTH-1:0]   last_idx, last_nxt, grant;
    logic [P_N_CHAN-1:0]      cand;
    logic [2*P_N_CHAN-1:0]    rot;
    int                       off, sum;
    logic                     req_nxt, mode_nxt, rdy_nxt, cont_nxt;
    logic [7:0]               idx_nxt, didx_nxt;
    logic [15:0]              len_nxt;

    // Rotate candidates so bit 0 is the channel just after last_idx; lowest set bit wins.
    always_comb begin
        cand = wvb_pending & chan_en;
        rot  = {cand, cand} >> (int'(last_idx) + 1);
        off  = 0;
        for (int k = P_N_CHAN - 1; k >= 0; k--)
            if (rot[k]) off = k;
        sum   = int'(last_idx) + 1 + off;
        grant = P_IDX_WIDTH'(sum >= P_N_CHAN ? sum - P_N_CHAN : sum);
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last_idx;
        req_nxt   = rd_req;
        idx_nxt   = rd_idx;
        mode_nxt  = rd_dpram_mode;
        rdy_nxt   = dpram_rdy;
        len_nxt   = dpram_len;
        didx_nxt  = dpram_idx;
        cont_nxt  = dpram_cont;
        case (state)
            S_IDLE: if (|cand) begin
                last_nxt  = grant;
                idx_nxt   = 8'(grant);
                mode_nxt  = cfg_dpram_mode;
                req_nxt   = 1'b1;
                state_nxt = S_REQ;
            end
            S_REQ: if (rd_ack) begin
                len_nxt   = rd_dpram_len;
                cont_nxt  = rd_more;
                didx_nxt  = rd_idx;
                req_nxt   = 1'b0;
                state_nxt = S_REL;
            end
            S_REL: if (!rd_ack) begin
                rdy_nxt   = 1'b1;
                state_nxt = S_HOST;
            end
            S_HOST: if (dpram_done) begin
                // A continuation goes straight back to the same channel without re-arbitration.
                rdy_nxt   = 1'b0;
                req_nxt   = dpram_cont;
                state_nxt = dpram_cont ? S_REQ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            last_idx      <= P_IDX_WIDTH'(P_N_CHAN - 1);
            rd_req        <= 1'b0;
            rd_idx        <= '0;
            rd_dpram_mode <= 1'b0;
            dpram_rdy     <= 1'b0;
            dpram_len     <= '0;
            dpram_idx     <= '0;
            dpram_cont    <= 1'b0;
        end else begin
            state         <= state_nxt;
            last_idx      <= last_nxt;
            rd_req        <= req_nxt;
            rd_idx        <= idx_nxt;
            rd_dpram_mode <= mode_nxt;
            dpram_rdy     <= rdy_nxt;
            dpram_len     <= len_nxt;
            dpram_idx     <= didx_nxt;
            dpram_cont    <= cont_nxt;
        end
    end

`ifdef WVB_RD_ARB_EVT_CNT_EN
    logic [31:0] evt_cnt;
    logic        evt_inc;
    assign evt_inc = (state == S_HOST) && dpram_done && !dpram_cont;
    always_ff @(posedge clk) begin
        if (!rst_n)       evt_cnt <= '0;
        else if (evt_inc) evt_cnt <= evt_cnt + 32'd1;
    end
    assign n_evt = evt_cnt;
`else
    assign n_evt = '0;
`endif
endmodule

// File: doc/wvb_rd_arb.md
# wvb_rd_arb

Round-robin scheduler that shares one waveform-buffer read controller, and the single direct-readout DPRAM it fills, among `P_N_CHAN` per-channel waveform buffers. It picks a channel with a pending waveform and sequences the read controller's `req`/`ack` handshake, including multi-DPRAM continuations. After each fill it hands the DPRAM to the host-side reader and waits for release before scheduling the next fill.

## Interface
Parameters:
- `P_N_CHAN`, 24: number of waveform buffers (1..256).
- `P_IDX_WIDTH`, 8: width of channel index; must satisfy 2^P_IDX_WIDTH ≥ P_N_CHAN.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `wvb_pending`  in  P_N_CHAN  bit i high = buffer i holds ≥1 complete waveform.
- `chan_en`  in  P_N_CHAN  per-channel enable mask from config registers.
- `cfg_dpram_mode`  in  1  0 = truncate at one DPRAM; 1 = extend across DPRAMs.
- `rd_req`  out  1  request to read controller.
- `rd_idx`  out  8  channel index; also drives the external wvb_data/hdr_data mux.
- `rd_dpram_mode`  out  1  mode presented to read controller.
- `rd_ack`  in  1  read controller done with current DPRAM fill.
- `rd_more`  in  1  fill ended mid-waveform; continuation required.
- `rd_dpram_len`  in  16  DPRAM fill length in 16-bit words, valid with `rd_ack`.
- `dpram_rdy`  out  1  DPRAM holds data for host.
- `dpram_len`  out  16  latched fill length, valid while `dpram_rdy`.
- `dpram_idx`  out  8  channel of the held data.
- `dpram_cont`  out  1  held data continues into the next fill of the same channel.
- `dpram_done`  in  1  single-cycle pulse: host finished reading DPRAM.
- `n_evt`  out  32  completed-waveform counter (see Configuration).

## Operation
- States: S_IDLE, S_REQ, S_REL, S_HOST.
- S_IDLE:
  - Compute `cand = wvb_pending & chan_en`.
  - If nonzero, grant the lowest set index strictly after `last_idx` (wrapping modulo P_N_CHAN); after reset, `last_idx` = P_N_CHAN-1, so index 0 is searched first.
  - Register `rd_idx` and `last_idx` = grant, latch `rd_dpram_mode` = `cfg_dpram_mode`, set `rd_req`=1, go to S_REQ.
- S_REQ: hold `rd_req`=1. On `rd_ack`=1:
  - latch `dpram_len`=`rd_dpram_len`, `dpram_cont`=`rd_more`, `dpram_idx`=`rd_idx`;
  - `rd_req`←0, go to S_REL.
- S_REL: wait for `rd_ack`=0, then set `dpram_rdy`=1 and go to S_HOST.
- S_HOST: wait for `dpram_done`. On the pulse, `dpram_rdy`←0, then:
  - if `dpram_cont`=1: `rd_req`←1 with `rd_idx` and `rd_dpram_mode` unchanged, go to S_REQ. Pending/enable are not re-examined, and a continuation is never preempted, even if `chan_en[idx]` drops.
  - else: increment `n_evt` and go to S_IDLE.
- Mode latching: `rd_dpram_mode` changes only in S_IDLE; `cfg_dpram_mode` changes mid-waveform have no effect on that waveform.
- `dpram_done` outside S_HOST is ignored.
- `rd_ack` arriving in S_IDLE or S_HOST is a protocol violation and is ignored (no state change).
- Grant indices ≥ P_N_CHAN are never produced; `rd_idx` is zero-extended to 8 bits.

## Timing
- Reset (`rst_n`=0 at clk edge): all outputs 0, `n_evt`=0, `last_idx`=P_N_CHAN-1, state S_IDLE. Reset mid-transaction aborts immediately; `rd_req` is low the cycle after the reset edge.
- Latencies:
  - `cand` nonzero in S_IDLE → `rd_req` high next cycle (1-cycle arbitration).
  - `rd_ack` high → `rd_req` low next cycle.
  - `rd_ack` low → `dpram_rdy` high next cycle.
  - `dpram_done` → `dpram_rdy` low next cycle; continuation `rd_req` high in that same cycle.
  - Minimum S_IDLE dwell is 1 cycle between waveforms.
- Pending deasserting in the same cycle the grant is registered does not cancel the request; the read controller is then responsible for the empty buffer.
- `dpram_len`, `dpram_idx` and `dpram_cont` are stable for the whole `dpram_rdy` interval.

## Configuration
- `WVB_RD_ARB_EVT_CNT_EN` defined:
  - `n_evt` is a 32-bit counter of completed waveforms (final non-continuation fills), wrapping at 2^32.
  - The counter is not incremented for continuation fills.
- Not defined: `n_evt` is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Single channel: pending=0x000004, enable all → `rd_idx`=2, `rd_req` high 1 cycle later; `rd_ack` with len=0x0040 → `dpram_rdy`=1, `dpram_len`=0x0040, `dpram_idx`=2; `dpram_done` → idle, `n_evt`=1.
- Round-robin: pending=0x000013 held → grant order 0,1,4,0,1; with `chan_en`=0x000012 → order 1,4,1.
- Continuation, mode 1: ch 5, first ack with `rd_more`=1 and len=2048 → `dpram_cont`=1; after `dpram_done`, `rd_req` re-asserts with idx 5 even after `chan_en[5]` is cleared; second ack with `rd_more`=0 → `n_evt` +1 only once.
- Mode latch: `cfg_dpram_mode` toggled 0→1 during S_HOST of a continued waveform → `rd_dpram_mode` stays at its latched value until the next S_IDLE grant.
- Reset mid-S_REQ with pending=0x1 → `rd_req`=0 next cycle; after release, the first grant is idx 0.
- Stray `dpram_done` in S_IDLE and stray `rd_ack` in S_HOST → no state or output change.
